// File: rtl/vld_seq.sv
// vld_seq: vector-load sequencer. Fetches up to NELEM consecutive 16-bit
// words from memory, one outstanding request at a time, and writes each one
// into a single element of a vector register file entry.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   start                 load request, sampled only while idle
//   baseAddr, vd, len     word address of element 0, destination register,
//                         element count (values above NELEM clamp to NELEM)
//   memReqValid/Addr      read request, held stable until memReqReady
//   memReqReady           memory accepts the request
//   memRespValid/Data     read return, one per accepted request
//   wEn/wAddr/wInd/wData  registered single-element register-file write
//   busy                  any state other than IDLE
//   done                  one-cycle completion pulse, coincides with last wEn
module vld_seq #(
  parameter int ADDR_W = 16,
  parameter int NELEM  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic [3:0]        vd,
  input  logic [4:0]        len,
  output logic              memReqValid,
  output logic [ADDR_W-1:0] memReqAddr,
  input  logic              memReqReady,
  input  logic              memRespValid,
  input  logic [15:0]       memRespData,
  output logic              wEn,
  output logic [3:0]        wAddr,
  output logic [3:0]        wInd,
  output logic [15:0]       wData,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [4:0] MAXLEN = 5'(NELEM);

  state_t            state, nextState;
  logic [3:0]        idx;
  logic [ADDR_W-1:0] baseL;
  logic [3:0]        vdL;
  logic [4:0]        lenL;
  logic [4:0]        lenClamp;
  logic              lastElem;

  assign lenClamp = (len > MAXLEN) ? MAXLEN : len;
  // lenL is never 0 while in WAIT, so lenL-1 cannot underflow there
  assign lastElem = ({1'b0, idx} == (lenL - 5'd1));

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (start) nextState = (lenClamp == 5'd0) ? DONE : REQ;
      REQ:  if (memReqReady) nextState = WAIT;
      WAIT: if (memRespValid) nextState = lastElem ? DONE : REQ;
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // outputs decoded from state; the request address is built from latched
  // operands only, so it cannot move while a request is waiting for ready
  always_comb begin
    memReqValid = (state == REQ);
    busy        = (state != IDLE);
    done        = (state == DONE);
    memReqAddr  = baseL + ADDR_W'(idx);
  end

  // operand latch and element counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      baseL <= '0;
      vdL   <= '0;
      lenL  <= '0;
    end else begin
      if (state == IDLE && start) begin
        baseL <= baseAddr;
        vdL   <= vd;
        lenL  <= lenClamp;
        idx   <= '0;
      end else if (state == WAIT && memRespValid && !lastElem) begin
        idx <= idx + 4'd1;
      end
    end
  end

  // register-file write port: one registered pulse per returned element
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wEn   <= 1'b0;
      wAddr <= '0;
      wInd  <= '0;
      wData <= '0;
    end else begin
      wEn <= 1'b0;
      if (state == WAIT && memRespValid) begin
        wEn   <= 1'b1;
        wAddr <= vdL;
        wInd  <= idx;
        wData <= memRespData;
      end
    end
  end

endmodule

// File: tb/tb_vld_seq.sv
module tb_vld_seq;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] baseAddr;
  logic [3:0]  vd;
  logic [4:0]  len;
  logic        memReqValid;
  logic [15:0] memReqAddr;
  logic        memReqReady;
  logic        memRespValid;
  logic [15:0] memRespData;
  logic        wEn;
  logic [3:0]  wAddr, wInd;
  logic [15:0] wData;
  logic        busy, done;

  vld_seq #(.ADDR_W(16), .NELEM(16)) dut (
    .clk(clk), .rst(rst), .start(start), .baseAddr(baseAddr), .vd(vd),
    .len(len), .memReqValid(memReqValid), .memReqAddr(memReqAddr),
    .memReqReady(memReqReady), .memRespValid(memRespValid),
    .memRespData(memRespData), .wEn(wEn), .wAddr(wAddr), .wInd(wInd),
    .wData(wData), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int nVec = 0, nMis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: expected request addresses and expected {vd,ind,data} writes
  logic [15:0] addrQ[$];
  logic [23:0] wrQ[$];

  int          cycle = 0;
  bit          pending = 0;
  logic [15:0] pendAddr;
  int          reqCount = 0;
  int          stallElem = -1, stallLeft = 0;
  bit          spurArm = 0;
  int          rstElem = -1;
  bit          rstFired = 0, lateResp = 0;
  bit          scramble = 0, holdStart = 0;
  bit          doneSeen = 0, wEnAtDone = 0;
  int          busyCnt = 0, doneCycle = 0, startCycle = 0;

  // One clock: observe outputs at negedge, then drive the memory model for
  // the next posedge. Memory answers one cycle after accepting a request.
  task automatic cyc();
    logic [23:0] e;
    @(negedge clk);
    cycle++;
    if (busy) busyCnt++;
    if (wEn) begin
      if (wrQ.size() == 0) check("wEnExtra", 1, 0);
      else begin
        e = wrQ.pop_front();
        check("write", {8'h0, wAddr, wInd, wData}, {8'h0, e});
      end
    end
    if (done) begin
      doneSeen  = 1;
      doneCycle = cycle;
      wEnAtDone = wEn;
    end
    if (scramble) begin
      baseAddr = 16'($urandom);
      vd       = 4'($urandom);
      len      = 5'($urandom);
    end
    memRespValid = 0;
    if (pending) begin
      if (reqCount - 1 == rstElem) begin
        rst = 1;
        #1;
        check("rstOut", {4'h0, memReqValid, wEn, busy, done, wAddr, wInd, wData}, 0);
        rstFired = 1;
        pending  = 0;
        lateResp = 1;
        rstElem  = -1;
        memReqReady = 1;
        return;
      end
      memRespValid = 1;
      memRespData  = 16'hA000 + pendAddr;
      pending      = 0;
    end else if (lateResp) begin
      rst          = 0;
      memRespValid = 1;
      memRespData  = 16'hDEAD;
      lateResp     = 0;
    end else if (spurArm && memReqValid && reqCount == 3) begin
      memRespValid = 1;
      memRespData  = 16'hBEEF;
      spurArm      = 0;
    end
    memReqReady = 1;
    if (memReqValid) begin
      if (addrQ.size() == 0) check("reqExtra", 1, 0);
      else check("reqAddr", {16'h0, memReqAddr}, {16'h0, addrQ[0]});
      if (reqCount == stallElem && stallLeft > 0) begin
        memReqReady = 0;
        stallLeft--;
      end else begin
        pending  = 1;
        pendAddr = memReqAddr;
        reqCount++;
        if (addrQ.size() > 0) void'(addrQ.pop_front());
      end
    end
  endtask

  task automatic pushExp(input logic [15:0] base, input logic [3:0] vdv, input int n, input int nWr);
    logic [15:0] a;
    logic [3:0]  ind;
    for (int i = 0; i < n; i++) begin
      a   = base + 16'(i);
      ind = 4'(i);
      addrQ.push_back(a);
      if (i < nWr) wrQ.push_back({vdv, ind, 16'hA000 + a});
    end
  endtask

  task automatic runLoad(input logic [15:0] base, input logic [3:0] vdv, input logic [4:0] lenv, input int expLat);
    int l;
    l = (lenv > 5'd16) ? 16 : int'(lenv);
    pushExp(base, vdv, l, l);
    baseAddr = base; vd = vdv; len = lenv; start = 1;
    startCycle = cycle; doneSeen = 0; busyCnt = 0; reqCount = 0;
    cyc();
    if (!holdStart) start = 0;
    for (int k = 0; k < 300 && !doneSeen; k++) cyc();
    start = 0;
    scramble = 0;
    check("doneSeen", doneSeen, 1);
    if (expLat >= 0) begin
      check("latency", doneCycle - startCycle, expLat);
      check("busyCycles", busyCnt, expLat);
    end
    check("wEnWithDone", wEnAtDone, (l > 0));
    check("addrQEmpty", addrQ.size(), 0);
    check("wrQEmpty", wrQ.size(), 0);
    cyc();
    check("idleAfter", busy, 0);
    addrQ.delete();
    wrQ.delete();
  endtask

  initial begin
    rst = 1; start = 0; baseAddr = 0; vd = 0; len = 0;
    memReqReady = 0; memRespValid = 0; memRespData = 0;
    #2;
    check("resetOut", {4'h0, memReqValid, wEn, busy, done, wAddr, wInd, wData}, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    cyc();

    // full 16-element load, done 33 cycles after start is sampled
    runLoad(16'h0100, 4'd3, 5'd16, 33);
    // empty load: straight to DONE, no requests, no writes
    runLoad(16'h0040, 4'd5, 5'd0, 1);
    // address wrap
    runLoad(16'hFFFE, 4'd9, 5'd4, 9);

    // back-pressure on element 2
    stallElem = 2; stallLeft = 5;
    runLoad(16'h0200, 4'd1, 5'd6, 18);
    check("stallUsed", stallLeft, 0);
    stallElem = -1;

    // reset while waiting on element 7
    pushExp(16'h0500, 4'd6, 8, 7);
    baseAddr = 16'h0500; vd = 4'd6; len = 5'd16; start = 1; reqCount = 0;
    rstElem = 7; rstFired = 0;
    cyc();
    start = 0;
    for (int k = 0; k < 100 && !rstFired; k++) cyc();
    check("rstFired", rstFired, 1);
    cyc();  // releases rst and drives a late response
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("lateNoWen", {wEn, busy, memReqValid}, 0);
    end
    check("rstAddrQ", addrQ.size(), 0);
    check("rstWrQ", wrQ.size(), 0);
    addrQ.delete(); wrQ.delete();

    // start held, other inputs churned, spurious response in REQ, len clamp
    holdStart = 1; scramble = 1; spurArm = 1;
    runLoad(16'h0300, 4'd12, 5'd20, 33);
    holdStart = 0;
    check("spurUsed", spurArm, 0);

    // back-to-back with the minimum idle gap
    runLoad(16'h0400, 4'd7, 5'd2, 5);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
